scarv_cop_mpalu: RTL and testbench

SCARV_COP_MPALU -- requirements
Module: scarv_cop_mpalu

---
 rtl/scarv_cop_mpalu_if.sv | 30 +++
 rtl/scarv_cop_mpalu.sv | 128 ++++++++++++
 tb/tb_scarv_cop_mpalu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_mpalu_if.sv
// Issue/writeback bundle between the decode stage and the multi-precision ALU.
// The decode side drives operands; the ALU side returns the two-word writeback.
interface scarv_cop_mpalu_if #(
    parameter int unsigned W = 32
) ();
    localparam int unsigned SW = $clog2(2 * W);

    logic             malu_ivalid;
    logic [2:0]       malu_op;
    logic             malu_use_imm;
    logic [W-1:0]     malu_rs1;
    logic [W-1:0]     malu_rs2;
    logic [W-1:0]     malu_rs3;
    logic [SW-1:0]    id_imm;
    logic             malu_idone;
    logic             malu_busy;
    logic [W/8-1:0]   malu_rd_ben;
    logic             malu_rd_hi;
    logic [W-1:0]     malu_rd_wdata;

    modport master (
        output malu_ivalid, malu_op, malu_use_imm, malu_rs1, malu_rs2, malu_rs3, id_imm,
        input  malu_idone, malu_busy, malu_rd_ben, malu_rd_hi, malu_rd_wdata
    );

    modport slave (
        input  malu_ivalid, malu_op, malu_use_imm, malu_rs1, malu_rs2, malu_rs3, id_imm,
        output malu_idone, malu_busy, malu_rd_ben, malu_rd_hi, malu_rd_wdata
    );
endinterface

// File: rtl/scarv_cop_mpalu.sv
// Multi-precision ALU: 3-operand add/sub, double-word shifts and an iterative
// multiply-accumulate, each producing a 2W-bit result written back low word then high word.
module scarv_cop_mpalu #(
    parameter int unsigned W        = 32,
    parameter int unsigned MUL_BITS = 4
) (
    input logic              g_clk,
    input logic              g_resetn,
    scarv_cop_mpalu_if.slave malu
);
    localparam int unsigned SW    = $clog2(2 * W);
    localparam int unsigned NSTEP = W / MUL_BITS;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LastStep = CW'(NSTEP - 1);

    localparam logic [2:0] OpAdd3 = 3'd0;
    localparam logic [2:0] OpSub3 = 3'd1;
    localparam logic [2:0] OpSll  = 3'd2;
    localparam logic [2:0] OpSrl  = 3'd3;
    localparam logic [2:0] OpMac  = 3'd4;

    typedef enum logic [1:0] {StIdle, StMul, StWbLo, StWbHi} state_e;

    state_e          state_q, state_d;
    logic [2*W-1:0]  result_q, result_d;  // also serves as the MAC accumulator
    logic [CW-1:0]   step_q, step_d;

    logic [2*W-1:0]  rs1_x, rs2_x, rs3_x, pair;
    logic [2*W-1:0]  add3_r, sub3_r, sll_r, srl_r, partial;
    logic [SW-1:0]   amt;
    logic [MUL_BITS-1:0] digit;

    assign rs1_x  = {{W{1'b0}}, malu.malu_rs1};
    assign rs2_x  = {{W{1'b0}}, malu.malu_rs2};
    assign rs3_x  = {{W{1'b0}}, malu.malu_rs3};
    assign pair   = {malu.malu_rs1, malu.malu_rs2};
    assign amt    = malu.malu_use_imm ? malu.id_imm : malu.malu_rs3[SW-1:0];

    assign add3_r = rs1_x + rs2_x + rs3_x;
    assign sub3_r = rs1_x - rs2_x - rs3_x;
    assign sll_r  = pair << amt;
    assign srl_r  = pair >> amt;

    // One radix-2^MUL_BITS digit of rs2 per step, weighted by its position.
    assign digit   = malu.malu_rs2[step_q * MUL_BITS +: MUL_BITS];
    assign partial = (rs1_x * {{(2*W-MUL_BITS){1'b0}}, digit}) << (step_q * MUL_BITS);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= StIdle;
            result_q <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        step_d   = step_q;
        unique case (state_q)
            StIdle: begin
                if (malu.malu_ivalid) begin
                    case (malu.malu_op)
                        OpAdd3: begin result_d = add3_r; state_d = StWbLo; end
                        OpSub3: begin result_d = sub3_r; state_d = StWbLo; end
                        OpSll:  begin result_d = sll_r;  state_d = StWbLo; end
                        OpSrl:  begin result_d = srl_r;  state_d = StWbLo; end
                        OpMac: begin
                            result_d = rs3_x;
                            step_d   = '0;
                            state_d  = StMul;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StMul: begin
                if (!malu.malu_ivalid) begin
                    state_d = StIdle;
                end else begin
                    result_d = result_q + partial;
                    step_d   = step_q + 1'b1;
                    if (step_q == LastStep) begin
                        state_d = StWbLo;
                    end
                end
            end
            StWbLo: state_d = malu.malu_ivalid ? StWbHi : StIdle;
            StWbHi: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Writeback is suppressed whenever the issuer has withdrawn the instruction.
    always_comb begin
        malu.malu_idone    = 1'b0;
        malu.malu_busy     = (state_q != StIdle);
        malu.malu_rd_ben   = '0;
        malu.malu_rd_hi    = 1'b0;
        malu.malu_rd_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (malu.malu_ivalid && (malu.malu_op > OpMac)) begin
                    malu.malu_idone = 1'b1;
                end
            end
            StWbLo: begin
                if (malu.malu_ivalid) begin
                    malu.malu_rd_ben   = '1;
                    malu.malu_rd_wdata = result_q[W-1:0];
                end
            end
            StWbHi: begin
                if (malu.malu_ivalid) begin
                    malu.malu_rd_ben   = '1;
                    malu.malu_rd_hi    = 1'b1;
                    malu.malu_rd_wdata = result_q[2*W-1:W];
                    malu.malu_idone    = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_scarv_cop_mpalu.sv
// Directed bench for scarv_cop_mpalu at W=32, MUL_BITS=4: table of vectors with
// hand-computed results plus sequences for illegal op, abort, reset and back-to-back issue.
module tb_scarv_cop_mpalu;
    localparam int unsigned W = 32;

    logic g_clk;
    logic g_resetn;
    int   n_vec;
    int   n_err;

    scarv_cop_mpalu_if #(.W(W)) mif ();

    scarv_cop_mpalu #(.W(W), .MUL_BITS(4)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .malu     (mif)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        use_imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [5:0]  imm;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mif.malu_op      = v.op;
        mif.malu_use_imm = v.use_imm;
        mif.malu_rs1     = v.rs1;
        mif.malu_rs2     = v.rs2;
        mif.malu_rs3     = v.rs3;
        mif.id_imm       = v.imm;
        mif.malu_ivalid  = 1'b1;
    endtask

    // Entered just after a rising edge with the DUT idle; returns just after the
    // edge that ends the WB_HI cycle, leaving ivalid high.
    task automatic run_vec(input vec_t v);
        int lat;
        lat = (v.op == 3'd4) ? 10 : 2;
        drive(v);
        for (int c = 0; c <= lat; c++) begin
            @(negedge g_clk);
            if (c == lat - 1) begin
                chk($sformatf("%s C%0d lo", v.name, c), mif.malu_rd_wdata, v.lo);
                chk($sformatf("%s C%0d ben", v.name, c), {28'd0, mif.malu_rd_ben}, 32'hF);
                chk($sformatf("%s C%0d rd_hi", v.name, c), {31'd0, mif.malu_rd_hi}, 32'd0);
                chk($sformatf("%s C%0d idone", v.name, c), {31'd0, mif.malu_idone}, 32'd0);
                chk($sformatf("%s C%0d busy", v.name, c), {31'd0, mif.malu_busy}, 32'd1);
            end else if (c == lat) begin
                chk($sformatf("%s C%0d hi", v.name, c), mif.malu_rd_wdata, v.hi);
                chk($sformatf("%s C%0d ben", v.name, c), {28'd0, mif.malu_rd_ben}, 32'hF);
                chk($sformatf("%s C%0d rd_hi", v.name, c), {31'd0, mif.malu_rd_hi}, 32'd1);
                chk($sformatf("%s C%0d idone", v.name, c), {31'd0, mif.malu_idone}, 32'd1);
                chk($sformatf("%s C%0d busy", v.name, c), {31'd0, mif.malu_busy}, 32'd1);
            end else begin
                chk($sformatf("%s C%0d idone", v.name, c), {31'd0, mif.malu_idone}, 32'd0);
                chk($sformatf("%s C%0d ben", v.name, c), {28'd0, mif.malu_rd_ben}, 32'd0);
                chk($sformatf("%s C%0d wdata", v.name, c), mif.malu_rd_wdata, 32'd0);
                chk($sformatf("%s C%0d busy", v.name, c), {31'd0, mif.malu_busy},
                    (c != 0) ? 32'd1 : 32'd0);
            end
            @(posedge g_clk);
            #1;
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " idone"}, {31'd0, mif.malu_idone}, 32'd0);
        chk({nm, " ben"}, {28'd0, mif.malu_rd_ben}, 32'd0);
        chk({nm, " busy"}, {31'd0, mif.malu_busy}, 32'd0);
        chk({nm, " wdata"}, mif.malu_rd_wdata, 32'd0);
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        //          name         op    imm? rs1           rs2           rs3           imm    lo            hi
        vecs[0]  = '{"add3_max", 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0,  32'hFFFFFFFD, 32'h00000002};
        vecs[1]  = '{"sub3_neg", 3'd1, 1'b0, 32'h00000000, 32'h00000001, 32'h00000000, 6'd0,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2]  = '{"sll_i36",  3'd2, 1'b1, 32'h00000000, 32'h0000000F, 32'h00000000, 6'd36, 32'h00000000, 32'h000000F0};
        vecs[3]  = '{"srl_r63",  3'd3, 1'b0, 32'h80000000, 32'h00000000, 32'd63,       6'd5,  32'h00000001, 32'h00000000};
        vecs[4]  = '{"mac_max",  3'd4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0,  32'h00000000, 32'hFFFFFFFF};
        vecs[5]  = '{"mac_mix",  3'd4, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 6'd0,  32'h242D2081, 32'h0B00EA4E};
        vecs[6]  = '{"add3_123", 3'd0, 1'b0, 32'd1,        32'd2,        32'd3,        6'd0,  32'd6,        32'd0};
        vecs[7]  = '{"sll_r0",   3'd2, 1'b0, 32'hDEADBEEF, 32'h12345678, 32'h00000040, 6'd9,  32'h12345678, 32'hDEADBEEF};
        vecs[8]  = '{"srl_i32",  3'd3, 1'b1, 32'hCAFEF00D, 32'h00000001, 32'h0000003F, 6'd32, 32'hCAFEF00D, 32'h00000000};
        vecs[9]  = '{"mac_zero", 3'd4, 1'b0, 32'h00000000, 32'h0000FFFF, 32'h00000005, 6'd0,  32'h00000005, 32'h00000000};
        vecs[10] = '{"sub3_pos", 3'd1, 1'b0, 32'd16,       32'd3,        32'd4,        6'd0,  32'd9,        32'd0};
        vecs[11] = '{"mac_21",   3'd4, 1'b0, 32'd3,        32'd7,        32'd0,        6'd0,  32'h00000015, 32'd0};

        g_resetn         = 1'b0;
        mif.malu_ivalid  = 1'b0;
        mif.malu_op      = 3'd0;
        mif.malu_use_imm = 1'b0;
        mif.malu_rs1     = '0;
        mif.malu_rs2     = '0;
        mif.malu_rs3     = '0;
        mif.id_imm       = '0;
        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk_quiet("reset");
        chk("reset rd_hi", {31'd0, mif.malu_rd_hi}, 32'd0);
        @(posedge g_clk);
        #1;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            mif.malu_ivalid = 1'b0;
            @(posedge g_clk);
            #1;
        end

        // Illegal op completes combinationally in IDLE and never leaves it.
        v = vecs[0];
        v.op = 3'd7;
        drive(v);
        @(negedge g_clk);
        chk("illegal C0 idone", {31'd0, mif.malu_idone}, 32'd1);
        chk("illegal C0 ben", {28'd0, mif.malu_rd_ben}, 32'd0);
        chk("illegal C0 busy", {31'd0, mif.malu_busy}, 32'd0);
        @(posedge g_clk);
        #1;
        mif.malu_ivalid = 1'b0;
        @(negedge g_clk);
        chk_quiet("illegal after");
        @(posedge g_clk);
        #1;

        // Withdraw a MAC while it is in MUL.
        drive(vecs[4]);
        repeat (3) begin
            @(posedge g_clk);
            #1;
        end
        mif.malu_ivalid = 1'b0;
        @(negedge g_clk);
        chk("abort C3 idone", {31'd0, mif.malu_idone}, 32'd0);
        chk("abort C3 ben", {28'd0, mif.malu_rd_ben}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge g_clk);
            #1;
            @(negedge g_clk);
            chk($sformatf("abort +%0d idone", k + 1), {31'd0, mif.malu_idone}, 32'd0);
            chk($sformatf("abort +%0d busy", k + 1), {31'd0, mif.malu_busy}, 32'd0);
        end
        @(posedge g_clk);
        #1;

        // Reset in MAC C4, then a clean ADD3.
        drive(vecs[4]);
        repeat (4) begin
            @(posedge g_clk);
            #1;
        end
        @(negedge g_clk);
        chk("pre-reset C4 busy", {31'd0, mif.malu_busy}, 32'd1);
        g_resetn = 1'b0;
        mif.malu_ivalid = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk_quiet("reset C5");
        @(posedge g_clk);
        #1;
        run_vec(vecs[6]);
        mif.malu_ivalid = 1'b0;
        @(posedge g_clk);
        #1;

        // Back-to-back ADD3: second C0 is the cycle right after WB_HI.
        run_vec(vecs[0]);
        run_vec(vecs[6]);
        mif.malu_ivalid = 1'b0;
        @(posedge g_clk);
        #1;
        @(negedge g_clk);
        chk_quiet("final idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule
